tmr_seq_ctrl: RTL and testbench
===============================

Name: tmr_seq_ctrl

Overview:
Sequencer and write-port arbiter for the 16-bit timer's register interface (tmr_cnt_wr / tmr_prd_wr / tmr_con_wr / icb_wdat).
- Sequence: on start, programs count, period and control, then services each timer interrupt by writing the clear-pending bit.
- Stop: disables the timer after a programmable interrupt count, or on stop.
- Arbitration: shares the same write port with a CPU requester.
- Placement: sits between the bus/CPU side and the timer, on sys_clk.

Parameters:
- DW, 16, register and data width.
- ENA_BIT, 0, tmr_con enable bit.
- CLR_BIT, 10, tmr_con clear-pending bit (write-1-to-clear).
- ICW, 8, width of interrupt counter and limit.

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse that launches a sequence; ignored when busy=1.
- stop  in  1  one-cycle pulse that aborts an active sequence; ignored in IDLE.
- cfg_cnt  in  DW  initial count value.
- cfg_prd  in  DW  period value.
- cfg_con  in  DW  control value; ENA_BIT and CLR_BIT are overridden by the block.
- irq_limit  in  ICW  number of interrupts to serve; 0 means unlimited.
- tmr_int  in  1  timer interrupt (level).
- cpu_wr_req  in  1  CPU write request; held until cpu_wr_ack.
- cpu_wr_sel  in  2  CPU write target: 0=cnt, 1=prd, 2=con, 3=none.
- cpu_wdat  in  DW  CPU write data.
- cpu_wr_ack  out  1  one-cycle grant/complete pulse.
- tmr_cnt_wr, tmr_prd_wr, tmr_con_wr  out  1 each  register write strobes, one-hot or all 0.
- icb_wdat  out  DW  write data.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse when a sequence ends.
- irq_cnt  out  ICW  interrupts served in the current or last sequence.

Behaviour:
- Register outputs: all outputs are registered.
- Reset values: all outputs are 0 and state is IDLE. Reset asserted mid-operation clears strobes asynchronously and stops the sequence with no further writes.
- Strobe timing: each write is a single-cycle strobe with icb_wdat valid in the same cycle. icb_wdat holds its last value afterwards.
- Start capture: cfg_cnt, cfg_prd, cfg_con and irq_limit are captured into shadow registers on the cycle start is accepted. irq_cnt clears to 0 on that same cycle.

State sequence, with start accepted at cycle N:
- WR_CNT (N+1): tmr_cnt_wr=1, icb_wdat=cfg_cnt.
- WR_PRD (N+2): tmr_prd_wr=1, icb_wdat=cfg_prd.
- WR_CON (N+3): tmr_con_wr=1, icb_wdat=cfg_con with ENA=1 and CLR=0.
- WAIT_INT: on sampling tmr_int=1, go to CLR.
- CLR (1 cycle):
  - tmr_con_wr=1, icb_wdat = shadow con with ENA=1 and CLR=1.
  - irq_cnt increments, saturating at all-ones.
  - Go to WAIT_LOW.
- WAIT_LOW:
  - Waits until tmr_int=0 so that one interrupt is not counted twice.
  - If irq_limit!=0 and irq_cnt==irq_limit, go to STOP_WR.
  - Otherwise go to WAIT_INT.
- STOP_WR (1 cycle): tmr_con_wr=1, icb_wdat = shadow con with ENA=0 and CLR=1. Go to DONE.
- DONE (1 cycle): done=1, then IDLE. busy is still 1 in DONE.

Stop handling:
- stop in WR_CNT/WR_PRD/WR_CON/CLR: the current strobe completes, then the next state is STOP_WR.
- stop in WAIT_INT/WAIT_LOW: next state is STOP_WR.
- stop coincident with tmr_int in WAIT_INT: stop wins; no CLR is written, and the STOP_WR write still clears pending.

Arbitration:
- The CPU is granted only in IDLE, WAIT_INT and WAIT_LOW, and only when the sequencer issues no write in the next cycle.
- When granted, in the following cycle:
  - cpu_wr_ack=1.
  - The strobe selected by cpu_wr_sel is driven with icb_wdat=cpu_wdat.
  - sel=3 gives an ack with no strobe.
- Sequencer priority: a start in IDLE, or tmr_int in WAIT_INT, beats a simultaneous cpu_wr_req. The CPU retries automatically by holding its request.
- No starvation: in WAIT_LOW the CPU always wins.
- Stop vs CPU: stop beats a simultaneous cpu_wr_req.
- At most one strobe per cycle, at all times.

Test Plan:
- Reset, then start with cfg_cnt=0x0000, cfg_prd=0x0020, cfg_con=0x0001, irq_limit=2.
  - Expect cnt_wr(0x0000) at N+1, prd_wr(0x0020) at N+2, con_wr(0x0001) at N+3.
  - On the first tmr_int: con_wr(0x0401) and irq_cnt=1.
  - On the second tmr_int: con_wr(0x0401), then con_wr(0x0400), done pulse, irq_cnt=2.
- irq_limit=0 with 5 interrupts → 5 clear writes of 0x0401 and irq_cnt=5; then stop → con_wr(0x0400) and done.
- tmr_int held high for 10 cycles in WAIT_INT → exactly one CLR write and irq_cnt increments once.
- cpu_wr_req sel=1, data 0x1234, issued in the same cycle as start in IDLE → sequencer writes at N+1..N+3; CPU ack with prd_wr(0x1234) no earlier than WAIT_INT. Check no two strobes are ever high together.
- stop asserted during WR_PRD → WR_CON still occurs, then con_wr(cfg_con with ENA=0, CLR=1), then done.
- sys_rst pulsed during WAIT_INT → all outputs 0 asynchronously, busy=0; a new start then runs a full sequence.

Source files
------------

// File: rtl/tmr_seq_ctrl_if.sv
// Write-port bundle shared by the timer sequencer and its CPU requester:
// CPU request/ack handshake plus the timer register write strobes and data.
interface tmr_seq_ctrl_if #(
    parameter int DW = 16
);
    logic          cpu_wr_req;
    logic [1:0]    cpu_wr_sel;
    logic [DW-1:0] cpu_wdat;
    logic          cpu_wr_ack;
    logic          tmr_cnt_wr;
    logic          tmr_prd_wr;
    logic          tmr_con_wr;
    logic [DW-1:0] icb_wdat;

    modport slave (
        input  cpu_wr_req, cpu_wr_sel, cpu_wdat,
        output cpu_wr_ack, tmr_cnt_wr, tmr_prd_wr, tmr_con_wr, icb_wdat
    );

    modport master (
        output cpu_wr_req, cpu_wr_sel, cpu_wdat,
        input  cpu_wr_ack, tmr_cnt_wr, tmr_prd_wr, tmr_con_wr, icb_wdat
    );
endinterface

// File: rtl/tmr_seq_ctrl.sv
// Timer programming sequencer: loads count/period/control, clears each interrupt,
// disables the timer after a limit or on stop, and arbitrates the write port with a CPU.
module tmr_seq_ctrl #(
    parameter int DW      = 16,
    parameter int ENA_BIT = 0,
    parameter int CLR_BIT = 10,
    parameter int ICW     = 8
) (
    input  logic           sys_clk,
    input  logic           sys_rst,
    input  logic           start,
    input  logic           stop,
    input  logic [DW-1:0]  cfg_cnt,
    input  logic [DW-1:0]  cfg_prd,
    input  logic [DW-1:0]  cfg_con,
    input  logic [ICW-1:0] irq_limit,
    input  logic           tmr_int,
    tmr_seq_ctrl_if.slave  bus,
    output logic           busy,
    output logic           done,
    output logic [ICW-1:0] irq_cnt
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_WR_CNT   = 4'd1,
        S_WR_PRD   = 4'd2,
        S_WR_CON   = 4'd3,
        S_WAIT_INT = 4'd4,
        S_CLR      = 4'd5,
        S_WAIT_LOW = 4'd6,
        S_STOP_WR  = 4'd7,
        S_DONE     = 4'd8
    } state_e;

    state_e         state_q, state_d;
    logic           stop_pend_q, stop_pend_d;
    logic [DW-1:0]  sh_cnt_q, sh_cnt_d;
    logic [DW-1:0]  sh_prd_q, sh_prd_d;
    logic [DW-1:0]  sh_con_q, sh_con_d;
    logic [ICW-1:0] sh_lim_q, sh_lim_d;
    logic [ICW-1:0] irq_cnt_q, irq_cnt_d;
    logic           cnt_wr_q, cnt_wr_d;
    logic           prd_wr_q, prd_wr_d;
    logic           con_wr_q, con_wr_d;
    logic [DW-1:0]  wdat_q, wdat_d;
    logic           ack_q, ack_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           grant_s;
    logic           cpu_req_s;

    function automatic logic [DW-1:0] con_word(input logic [DW-1:0] base,
                                               input logic ena, input logic clr);
        logic [DW-1:0] w;
        w          = base;
        w[ENA_BIT] = ena;
        w[CLR_BIT] = clr;
        return w;
    endfunction

    // A request still high during its own ack cycle must not be granted twice.
    assign cpu_req_s = bus.cpu_wr_req & ~ack_q;

    // Next-state, shadow capture, grant decision and registered-output preparation.
    always_comb begin
        state_d     = state_q;
        stop_pend_d = stop_pend_q;
        sh_cnt_d    = sh_cnt_q;
        sh_prd_d    = sh_prd_q;
        sh_con_d    = sh_con_q;
        sh_lim_d    = sh_lim_q;
        irq_cnt_d   = irq_cnt_q;
        grant_s     = 1'b0;
        cnt_wr_d    = 1'b0;
        prd_wr_d    = 1'b0;
        con_wr_d    = 1'b0;
        wdat_d      = wdat_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_WR_CNT;
                    stop_pend_d = 1'b0;
                    sh_cnt_d    = cfg_cnt;
                    sh_prd_d    = cfg_prd;
                    sh_con_d    = cfg_con;
                    sh_lim_d    = irq_limit;
                    irq_cnt_d   = '0;
                end else if (cpu_req_s) begin
                    grant_s = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            // A stop seen during a write lets the already-committed next write go out first.
            S_WR_CNT, S_WR_PRD, S_WR_CON, S_CLR: begin
                if (stop_pend_q) begin
                    state_d = S_STOP_WR;
                end else if (state_q == S_WR_CNT) begin
                    state_d = S_WR_PRD;
                end else if (state_q == S_WR_PRD) begin
                    state_d = S_WR_CON;
                end else if (state_q == S_WR_CON) begin
                    state_d = S_WAIT_INT;
                end else begin
                    state_d = S_WAIT_LOW;
                end
                if (stop) begin
                    stop_pend_d = 1'b1;
                end else begin
                    stop_pend_d = stop_pend_q;
                end
            end
            S_WAIT_INT: begin
                if (stop || stop_pend_q) begin
                    state_d = S_STOP_WR;
                end else if (tmr_int) begin
                    state_d = S_CLR;
                    if (irq_cnt_q != {ICW{1'b1}}) begin
                        irq_cnt_d = irq_cnt_q + ICW'(1);
                    end else begin
                        irq_cnt_d = irq_cnt_q;
                    end
                end else if (cpu_req_s) begin
                    grant_s = 1'b1;
                end else begin
                    state_d = S_WAIT_INT;
                end
            end
            // CPU is served before the limit check so it can never be starved here.
            S_WAIT_LOW: begin
                if (stop || stop_pend_q) begin
                    state_d = S_STOP_WR;
                end else if (cpu_req_s) begin
                    grant_s = 1'b1;
                end else if (!tmr_int) begin
                    if ((sh_lim_q != '0) && (irq_cnt_q == sh_lim_q)) begin
                        state_d = S_STOP_WR;
                    end else begin
                        state_d = S_WAIT_INT;
                    end
                end else begin
                    state_d = S_WAIT_LOW;
                end
            end
            S_STOP_WR: begin
                state_d     = S_DONE;
                stop_pend_d = 1'b0;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        case (state_d)
            S_WR_CNT: begin
                cnt_wr_d = 1'b1;
                wdat_d   = sh_cnt_d;
            end
            S_WR_PRD: begin
                prd_wr_d = 1'b1;
                wdat_d   = sh_prd_d;
            end
            S_WR_CON: begin
                con_wr_d = 1'b1;
                wdat_d   = con_word(sh_con_d, 1'b1, 1'b0);
            end
            S_CLR: begin
                con_wr_d = 1'b1;
                wdat_d   = con_word(sh_con_d, 1'b1, 1'b1);
            end
            S_STOP_WR: begin
                con_wr_d = 1'b1;
                wdat_d   = con_word(sh_con_d, 1'b0, 1'b1);
            end
            default: begin
                if (grant_s) begin
                    case (bus.cpu_wr_sel)
                        2'd0:    cnt_wr_d = 1'b1;
                        2'd1:    prd_wr_d = 1'b1;
                        2'd2:    con_wr_d = 1'b1;
                        default: cnt_wr_d = 1'b0;
                    endcase
                    if (bus.cpu_wr_sel != 2'd3) begin
                        wdat_d = bus.cpu_wdat;
                    end else begin
                        wdat_d = wdat_q;
                    end
                end else begin
                    wdat_d = wdat_q;
                end
            end
        endcase

        ack_d  = grant_s;
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State, shadow and output registers.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= S_IDLE;
            stop_pend_q <= 1'b0;
            sh_cnt_q    <= '0;
            sh_prd_q    <= '0;
            sh_con_q    <= '0;
            sh_lim_q    <= '0;
            irq_cnt_q   <= '0;
            cnt_wr_q    <= 1'b0;
            prd_wr_q    <= 1'b0;
            con_wr_q    <= 1'b0;
            wdat_q      <= '0;
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            stop_pend_q <= stop_pend_d;
            sh_cnt_q    <= sh_cnt_d;
            sh_prd_q    <= sh_prd_d;
            sh_con_q    <= sh_con_d;
            sh_lim_q    <= sh_lim_d;
            irq_cnt_q   <= irq_cnt_d;
            cnt_wr_q    <= cnt_wr_d;
            prd_wr_q    <= prd_wr_d;
            con_wr_q    <= con_wr_d;
            wdat_q      <= wdat_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.cpu_wr_ack = ack_q;
    assign bus.tmr_cnt_wr = cnt_wr_q;
    assign bus.tmr_prd_wr = prd_wr_q;
    assign bus.tmr_con_wr = con_wr_q;
    assign bus.icb_wdat   = wdat_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign irq_cnt        = irq_cnt_q;

endmodule

// File: tb/tb_tmr_seq_ctrl.sv
// Directed bench for tmr_seq_ctrl: hand-computed write sequences, stop, CPU arbitration, reset.
module tb_tmr_seq_ctrl;

    logic        sys_clk;
    logic        sys_rst;
    logic        start;
    logic        stop;
    logic [15:0] cfg_cnt;
    logic [15:0] cfg_prd;
    logic [15:0] cfg_con;
    logic [7:0]  irq_limit;
    logic        tmr_int;
    logic        busy;
    logic        done;
    logic [7:0]  irq_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    tmr_seq_ctrl_if #(.DW(16)) bus ();

    tmr_seq_ctrl #(.DW(16), .ENA_BIT(0), .CLR_BIT(10), .ICW(8)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .start     (start),
        .stop      (stop),
        .cfg_cnt   (cfg_cnt),
        .cfg_prd   (cfg_prd),
        .cfg_con   (cfg_con),
        .irq_limit (irq_limit),
        .tmr_int   (tmr_int),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .irq_cnt   (irq_cnt)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // strb = {cnt_wr, prd_wr, con_wr}
    task automatic exp_wr(input string tag, input logic [2:0] strb, input logic [15:0] wdat);
        check_val(tag, {29'd0, bus.tmr_cnt_wr, bus.tmr_prd_wr, bus.tmr_con_wr}, {29'd0, strb});
        if (strb != 3'b000) check_val({tag, "_wdat"}, {16'd0, bus.icb_wdat}, {16'd0, wdat});
    endtask

    // Start a sequence and check the three programming writes, ending in WAIT_INT.
    task automatic run_prog(input string tag, input logic [15:0] c, input logic [15:0] p,
                            input logic [15:0] k, input logic [7:0] lim, input logic [15:0] con_exp);
        cfg_cnt = c; cfg_prd = p; cfg_con = k; irq_limit = lim;
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_wr({tag, "_cnt"}, 3'b100, c);
        check_val({tag, "_busy"}, {31'd0, busy}, 32'd1);
        tick();
        exp_wr({tag, "_prd"}, 3'b010, p);
        tick();
        exp_wr({tag, "_con"}, 3'b001, con_exp);
        tick();
        exp_wr({tag, "_waitint"}, 3'b000, 16'h0000);
        check_val({tag, "_irq0"}, {24'd0, irq_cnt}, 32'd0);
    endtask

    // At most one strobe in any cycle.
    always @(negedge sys_clk) begin
        check_val("strobe_onehot",
                  {31'd0, ({2'b00, bus.tmr_cnt_wr} + {2'b00, bus.tmr_prd_wr} + {2'b00, bus.tmr_con_wr}) > 3'd1},
                  32'd0);
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int ncon;
        int idx;
        logic found;

        sys_rst = 1'b1; start = 1'b0; stop = 1'b0; tmr_int = 1'b0;
        cfg_cnt = 16'h0000; cfg_prd = 16'h0000; cfg_con = 16'h0000; irq_limit = 8'd0;
        bus.cpu_wr_req = 1'b0; bus.cpu_wr_sel = 2'd3; bus.cpu_wdat = 16'h0000;
        repeat (3) tick();
        sys_rst = 1'b0;
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_done", {31'd0, done}, 32'd0);
        check_val("rst_irq", {24'd0, irq_cnt}, 32'd0);
        check_val("rst_ack", {31'd0, bus.cpu_wr_ack}, 32'd0);
        check_val("rst_wdat", {16'd0, bus.icb_wdat}, 32'd0);
        exp_wr("rst_strb", 3'b000, 16'h0000);
        tick();

        // limit 2: two clears then the disable write
        run_prog("t1", 16'h0000, 16'h0020, 16'h0001, 8'd2, 16'h0001);
        tmr_int = 1'b1; tick();
        exp_wr("t1_clr1", 3'b001, 16'h0401);
        check_val("t1_irq1", {24'd0, irq_cnt}, 32'd1);
        tick();
        exp_wr("t1_wlow", 3'b000, 16'h0000);
        tmr_int = 1'b0; tick();
        exp_wr("t1_wint", 3'b000, 16'h0000);
        tmr_int = 1'b1; tick();
        exp_wr("t1_clr2", 3'b001, 16'h0401);
        check_val("t1_irq2", {24'd0, irq_cnt}, 32'd2);
        tmr_int = 1'b0; tick();
        exp_wr("t1_wlow2", 3'b000, 16'h0000);
        tick();
        exp_wr("t1_stopwr", 3'b001, 16'h0400);
        check_val("t1_done_early", {31'd0, done}, 32'd0);
        tick();
        check_val("t1_done", {31'd0, done}, 32'd1);
        check_val("t1_busy_done", {31'd0, busy}, 32'd1);
        exp_wr("t1_done_strb", 3'b000, 16'h0000);
        tick();
        check_val("t1_idle_busy", {31'd0, busy}, 32'd0);
        check_val("t1_idle_done", {31'd0, done}, 32'd0);
        check_val("t1_irq_hold", {24'd0, irq_cnt}, 32'd2);

        // unlimited: five clears, then stop
        run_prog("t2", 16'h0007, 16'h0020, 16'h0001, 8'd0, 16'h0001);
        for (int i = 1; i <= 5; i++) begin
            tmr_int = 1'b1; tick();
            exp_wr("t2_clr", 3'b001, 16'h0401);
            check_val("t2_irq", {24'd0, irq_cnt}, i);
            tmr_int = 1'b0; tick();
            tick();
            exp_wr("t2_wint", 3'b000, 16'h0000);
        end
        stop = 1'b1; tick();
        stop = 1'b0;
        exp_wr("t2_stopwr", 3'b001, 16'h0400);
        tick();
        check_val("t2_done", {31'd0, done}, 32'd1);
        check_val("t2_irq5", {24'd0, irq_cnt}, 32'd5);
        tick();

        // level interrupt held 10 cycles counts once; CPU wins in WAIT_LOW
        run_prog("t3", 16'h0001, 16'h0002, 16'h0001, 8'd0, 16'h0001);
        ncon = 0;
        tmr_int = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.tmr_con_wr) ncon++;
        end
        check_val("t3_one_clr", ncon, 32'd1);
        check_val("t3_irq", {24'd0, irq_cnt}, 32'd1);
        bus.cpu_wr_req = 1'b1; bus.cpu_wr_sel = 2'd0; bus.cpu_wdat = 16'hBEEF;
        tick();
        bus.cpu_wr_req = 1'b0;
        check_val("t3_ack", {31'd0, bus.cpu_wr_ack}, 32'd1);
        exp_wr("t3_cpu_cnt", 3'b100, 16'hBEEF);
        tick();
        check_val("t3_ack_pulse", {31'd0, bus.cpu_wr_ack}, 32'd0);
        tmr_int = 1'b0; tick();
        tick();
        check_val("t3_irq_after", {24'd0, irq_cnt}, 32'd1);
        stop = 1'b1; tick();
        stop = 1'b0;
        exp_wr("t3_stopwr", 3'b001, 16'h0400);
        tick();
        check_val("t3_done", {31'd0, done}, 32'd1);
        tick();

        // CPU writes in IDLE: sel=3 acks without a strobe, sel=2 hits con
        bus.cpu_wr_req = 1'b1; bus.cpu_wr_sel = 2'd3; bus.cpu_wdat = 16'h5555;
        tick();
        bus.cpu_wr_req = 1'b0;
        check_val("idle_sel3_ack", {31'd0, bus.cpu_wr_ack}, 32'd1);
        exp_wr("idle_sel3_strb", 3'b000, 16'h0000);
        tick();
        bus.cpu_wr_req = 1'b1; bus.cpu_wr_sel = 2'd2; bus.cpu_wdat = 16'h00F0;
        tick();
        bus.cpu_wr_req = 1'b0;
        check_val("idle_sel2_ack", {31'd0, bus.cpu_wr_ack}, 32'd1);
        exp_wr("idle_sel2_con", 3'b001, 16'h00F0);
        tick();

        // start and CPU request together: sequencer first, CPU once waiting
        cfg_cnt = 16'h0003; cfg_prd = 16'h0044; cfg_con = 16'h0001; irq_limit = 8'd0;
        start = 1'b1;
        bus.cpu_wr_req = 1'b1; bus.cpu_wr_sel = 2'd1; bus.cpu_wdat = 16'h1234;
        tick();
        start = 1'b0;
        check_val("t4_ack_n1", {31'd0, bus.cpu_wr_ack}, 32'd0);
        exp_wr("t4_cnt", 3'b100, 16'h0003);
        tick();
        check_val("t4_ack_n2", {31'd0, bus.cpu_wr_ack}, 32'd0);
        exp_wr("t4_prd", 3'b010, 16'h0044);
        tick();
        check_val("t4_ack_n3", {31'd0, bus.cpu_wr_ack}, 32'd0);
        exp_wr("t4_con", 3'b001, 16'h0001);
        found = 1'b0;
        idx = 3;
        while (!found && idx < 12) begin
            tick();
            idx++;
            found = bus.cpu_wr_ack;
        end
        bus.cpu_wr_req = 1'b0;
        check_val("t4_ack_seen", {31'd0, found}, 32'd1);
        check_val("t4_ack_not_early", {31'd0, idx >= 4}, 32'd1);
        exp_wr("t4_cpu_prd", 3'b010, 16'h1234);
        tick();
        check_val("t4_ack_pulse", {31'd0, bus.cpu_wr_ack}, 32'd0);
        stop = 1'b1; tick();
        stop = 1'b0;
        exp_wr("t4_stopwr", 3'b001, 16'h0400);
        tick();
        check_val("t4_done", {31'd0, done}, 32'd1);
        tick();

        // stop during WR_PRD: WR_CON still goes out, then disable
        cfg_cnt = 16'h00AA; cfg_prd = 16'h0055; cfg_con = 16'h8402; irq_limit = 8'd0;
        start = 1'b1; tick();
        start = 1'b0;
        exp_wr("t5_cnt", 3'b100, 16'h00AA);
        tick();
        exp_wr("t5_prd", 3'b010, 16'h0055);
        stop = 1'b1; tick();
        stop = 1'b0;
        exp_wr("t5_con", 3'b001, 16'h8003);
        tick();
        exp_wr("t5_stopwr", 3'b001, 16'h8402);
        tick();
        check_val("t5_done", {31'd0, done}, 32'd1);
        exp_wr("t5_done_strb", 3'b000, 16'h0000);
        tick();
        check_val("t5_idle", {31'd0, busy}, 32'd0);

        // async reset in WAIT_INT, then a full sequence with limit 1
        run_prog("t6a", 16'h0010, 16'h0100, 16'h0001, 8'd1, 16'h0001);
        #3;
        sys_rst = 1'b1;
        #1;
        check_val("t6_rst_busy", {31'd0, busy}, 32'd0);
        check_val("t6_rst_wdat", {16'd0, bus.icb_wdat}, 32'd0);
        check_val("t6_rst_irq", {24'd0, irq_cnt}, 32'd0);
        exp_wr("t6_rst_strb", 3'b000, 16'h0000);
        tick();
        sys_rst = 1'b0;
        tick();
        check_val("t6_still_idle", {31'd0, busy}, 32'd0);
        run_prog("t6b", 16'h0010, 16'h0100, 16'h0001, 8'd1, 16'h0001);
        tmr_int = 1'b1; tick();
        exp_wr("t6_clr", 3'b001, 16'h0401);
        check_val("t6_irq1", {24'd0, irq_cnt}, 32'd1);
        tmr_int = 1'b0; tick();
        tick();
        exp_wr("t6_stopwr", 3'b001, 16'h0400);
        tick();
        check_val("t6_done", {31'd0, done}, 32'd1);
        tick();
        check_val("t6_end_busy", {31'd0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
